// File: rtl/control_sequencer_if.sv
// Control sequencer bundle: machine-state inputs (run, opcode, flags) and
// the active-high control word plus status produced by the sequencer.
interface control_sequencer_if;
    logic       run;
    logic [3:0] opcode;
    logic       cf;
    logic       zf;

    logic       pc_out;
    logic       pc_inc;
    logic       pc_load;
    logic       mar_load;
    logic       ram_out;
    logic       ir_load;
    logic       ir_out;
    logic       a_load;
    logic       a_out;
    logic       b_load;
    logic       alu_out;
    logic       sub;
    logic       flags_load;
    logic       out_load;

    logic       halted;
    logic [2:0] tstate;
    logic [7:0] instr_count;

    // Sequencer side: consumes machine state, drives the control word.
    modport master (
        input  run, opcode, cf, zf,
        output pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, alu_out, sub, flags_load, out_load,
               halted, tstate, instr_count
    );

    // Datapath side: supplies machine state, consumes the control word.
    modport slave (
        output run, opcode, cf, zf,
        input  pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, alu_out, sub, flags_load, out_load,
               halted, tstate, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Micro-step control sequencer for a simple accumulator machine.
// Registered micro-step counter (T0..T5), halt latch and retired-instruction
// counter; the control word is a Moore decode of the registered step, the
// current opcode and the ALU flags, forced to zero while paused, halted or
// in reset.
module control_sequencer #(
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter logic [3:0] JC_OPCODE   = 4'h7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_sequencer_if.master  bus
);

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;

    // Bit positions of the control word, MSB first.
    localparam int CW_PC_OUT     = 13;
    localparam int CW_PC_INC     = 12;
    localparam int CW_PC_LOAD    = 11;
    localparam int CW_MAR_LOAD   = 10;
    localparam int CW_RAM_OUT    = 9;
    localparam int CW_IR_LOAD    = 8;
    localparam int CW_IR_OUT     = 7;
    localparam int CW_A_LOAD     = 6;
    localparam int CW_A_OUT      = 5;
    localparam int CW_B_LOAD     = 4;
    localparam int CW_ALU_OUT    = 3;
    localparam int CW_SUB        = 2;
    localparam int CW_FLAGS_LOAD = 1;
    localparam int CW_OUT_LOAD   = 0;

    logic [2:0]  tstate_r;
    logic        halted_r;
    logic [7:0]  count_r;

    logic        advance_s;
    logic        instr_end_s;
    logic [2:0]  last_step_s;
    logic [2:0]  next_tstate_s;
    logic        ctrl_en_s;
    logic [13:0] ctrl_s;
    logic [13:0] ctrl_gated_s;

    // Final micro-step of each instruction; HLT takes priority over any
    // opcode it might alias.
    function automatic logic [2:0] last_step_f(input logic [3:0] op);
        logic [2:0] step;
        if (op == HALT_OPCODE) begin
            step = T2;
        end else if (op == OP_LDA) begin
            step = T3;
        end else if ((op == OP_ADD) || (op == OP_SUB)) begin
            step = T4;
        end else begin
            step = T2;
        end
        return step;
    endfunction

    // Next-step selection: wrap to T0 after the last step or from unused T5.
    always_comb begin
        advance_s     = bus.run & ~halted_r;
        last_step_s   = last_step_f(bus.opcode);
        instr_end_s   = advance_s & (tstate_r == last_step_s);
        next_tstate_s = tstate_r + 3'd1;
        if (instr_end_s || (tstate_r == T5)) begin
            next_tstate_s = T0;
        end else begin
            next_tstate_s = tstate_r + 3'd1;
        end
    end

    // Step counter, halt latch and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstate_r <= T0;
            halted_r <= 1'b0;
            count_r  <= 8'd0;
        end else if (advance_s) begin
            tstate_r <= next_tstate_s;
            if (instr_end_s) begin
                count_r <= count_r + 8'd1;
                if (bus.opcode == HALT_OPCODE) begin
                    halted_r <= 1'b1;
                end
            end
        end
    end

    // Micro-code decode of the registered step against opcode and flags.
    always_comb begin
        ctrl_s = 14'd0;
        case (tstate_r)
            T0: begin
                ctrl_s[CW_PC_OUT]   = 1'b1;
                ctrl_s[CW_MAR_LOAD] = 1'b1;
            end
            T1: begin
                ctrl_s[CW_RAM_OUT]  = 1'b1;
                ctrl_s[CW_IR_LOAD]  = 1'b1;
                ctrl_s[CW_PC_INC]   = 1'b1;
            end
            T2: begin
                if (bus.opcode == HALT_OPCODE) begin
                    ctrl_s = 14'd0;
                end else if (bus.opcode == JC_OPCODE) begin
                    ctrl_s[CW_IR_OUT]  = bus.cf;
                    ctrl_s[CW_PC_LOAD] = bus.cf;
                end else if (bus.opcode == OP_JZ) begin
                    ctrl_s[CW_IR_OUT]  = bus.zf;
                    ctrl_s[CW_PC_LOAD] = bus.zf;
                end else begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl_s[CW_IR_OUT]   = 1'b1;
                            ctrl_s[CW_MAR_LOAD] = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl_s[CW_IR_OUT]  = 1'b1;
                            ctrl_s[CW_PC_LOAD] = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl_s[CW_A_OUT]    = 1'b1;
                            ctrl_s[CW_OUT_LOAD] = 1'b1;
                        end
                        default: ctrl_s = 14'd0;
                    endcase
                end
            end
            T3: begin
                if (bus.opcode == HALT_OPCODE) begin
                    ctrl_s = 14'd0;
                end else begin
                    case (bus.opcode)
                        OP_LDA: begin
                            ctrl_s[CW_RAM_OUT] = 1'b1;
                            ctrl_s[CW_A_LOAD]  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl_s[CW_RAM_OUT] = 1'b1;
                            ctrl_s[CW_B_LOAD]  = 1'b1;
                        end
                        default: ctrl_s = 14'd0;
                    endcase
                end
            end
            T4: begin
                if (bus.opcode == HALT_OPCODE) begin
                    ctrl_s = 14'd0;
                end else begin
                    case (bus.opcode)
                        OP_ADD: begin
                            ctrl_s[CW_ALU_OUT]    = 1'b1;
                            ctrl_s[CW_A_LOAD]     = 1'b1;
                            ctrl_s[CW_FLAGS_LOAD] = 1'b1;
                        end
                        OP_SUB: begin
                            ctrl_s[CW_ALU_OUT]    = 1'b1;
                            ctrl_s[CW_A_LOAD]     = 1'b1;
                            ctrl_s[CW_FLAGS_LOAD] = 1'b1;
                            ctrl_s[CW_SUB]        = 1'b1;
                        end
                        default: ctrl_s = 14'd0;
                    endcase
                end
            end
            default: ctrl_s = 14'd0;
        endcase
    end

    // Control word is silent in reset, while paused and once halted.
    always_comb begin
        ctrl_en_s = rst_n & bus.run & ~halted_r;
        if (ctrl_en_s) begin
            ctrl_gated_s = ctrl_s;
        end else begin
            ctrl_gated_s = 14'd0;
        end
    end

    assign bus.pc_out      = ctrl_gated_s[CW_PC_OUT];
    assign bus.pc_inc      = ctrl_gated_s[CW_PC_INC];
    assign bus.pc_load     = ctrl_gated_s[CW_PC_LOAD];
    assign bus.mar_load    = ctrl_gated_s[CW_MAR_LOAD];
    assign bus.ram_out     = ctrl_gated_s[CW_RAM_OUT];
    assign bus.ir_load     = ctrl_gated_s[CW_IR_LOAD];
    assign bus.ir_out      = ctrl_gated_s[CW_IR_OUT];
    assign bus.a_load      = ctrl_gated_s[CW_A_LOAD];
    assign bus.a_out       = ctrl_gated_s[CW_A_OUT];
    assign bus.b_load      = ctrl_gated_s[CW_B_LOAD];
    assign bus.alu_out     = ctrl_gated_s[CW_ALU_OUT];
    assign bus.sub         = ctrl_gated_s[CW_SUB];
    assign bus.flags_load  = ctrl_gated_s[CW_FLAGS_LOAD];
    assign bus.out_load    = ctrl_gated_s[CW_OUT_LOAD];

    assign bus.halted      = halted_r;
    assign bus.tstate      = tstate_r;
    assign bus.instr_count = count_r;

endmodule
